// File: rtl/prbs_pkg.sv
// Constants and helpers for the PRBS9 BER link, shared by the transmit source
// and the receiver-side BER block.
package prbs_pkg;

    localparam int PRBS9_W      = 9;
    localparam int PRBS9_TAP_A  = 8;
    localparam int PRBS9_TAP_B  = 4;
    localparam int PRBS9_PERIOD = 511;
    localparam int CNT_W        = 64;

    // x^9 + x^5 + 1, shifting towards the MSB which is the emitted bit.
    function automatic logic [PRBS9_W-1:0] prbs9_next(input logic [PRBS9_W-1:0] s);
        return {s[PRBS9_W-2:0], s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 register with seed load, advance strobe and an all-zero lock-up guard.
// Also used as the receiver's local reference generator.
module prbs9_lfsr
    import prbs_pkg::*;
#(
    parameter logic [PRBS9_W-1:0] SEED = 9'h1AA
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic advance,
    output logic msb,
    output logic locked
);

    logic [PRBS9_W-1:0] state;

    // An upset into the all-zero state would stall the sequence forever, so
    // the seed is reloaded on the next enabled edge instead of advancing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED;
        end else if (enable) begin
            if (state == '0) begin
                state <= SEED;
            end else if (advance) begin
                state <= prbs9_next(state);
            end
        end
    end

    assign msb    = state[PRBS9_TAP_A];
    assign locked = (state == '0);

endmodule

// File: rtl/prbs9_tx_source.sv
// Transmit-side PRBS9 stimulus source: baud-rate symbol strobe, clean reference
// bit, error-injectable transmit bit and saturating VIO counters.
module prbs9_tx_source
    import prbs_pkg::*;
#(
    parameter logic [PRBS9_W-1:0] SEED       = 9'h1AA,
    parameter int                 OS         = 4,
    parameter int                 ERR_PERIOD = 0
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_err_inj_en,
    output logic             o_valid,
    output logic             o_prbs_ref,
    output logic             o_tx_bit,
    output logic             o_sof,
    output logic [CNT_W-1:0] o_counterBit,
    output logic [CNT_W-1:0] o_counterInj
);

    localparam int INJ_W = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

    if (SEED == '0) begin : g_bad_seed
        $error("prbs9_tx_source: SEED must be non-zero");
    end
    if (OS < 1 || OS > 255) begin : g_bad_os
        $error("prbs9_tx_source: OS must be in 1..255");
    end
    if (ERR_PERIOD < 0) begin : g_bad_err_period
        $error("prbs9_tx_source: ERR_PERIOD must be non-negative");
    end

    logic [7:0]         tick;
    logic [8:0]         seq_idx;
    logic [INJ_W-1:0]   inj_cnt;
    logic               lfsr_msb;
    logic               lfsr_locked;
    logic               tick_last;
    logic               inj_last;
    logic               symbol;
    logic               inject;
    logic [CNT_W-1:0]   cnt_bit;
    logic [CNT_W-1:0]   cnt_inj;

    assign tick_last = (tick == 8'(OS - 1));
    assign inj_last  = (ERR_PERIOD != 0) && (inj_cnt == INJ_W'(ERR_PERIOD - 1));
    // A lock-up reload edge takes the place of the symbol it would have emitted.
    assign symbol    = i_enable && tick_last && !lfsr_locked;
    assign inject    = symbol && inj_last && i_err_inj_en;

    prbs9_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset   (i_reset),
        .enable  (i_enable),
        .advance (symbol),
        .msb     (lfsr_msb),
        .locked  (lfsr_locked)
    );

    always_ff @(posedge clock) begin
        if (i_reset) begin
            tick <= '0;
        end else if (i_enable) begin
            tick <= tick_last ? 8'd0 : tick + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            seq_idx <= '0;
            inj_cnt <= '0;
        end else if (symbol) begin
            seq_idx <= (seq_idx == 9'(PRBS9_PERIOD - 1)) ? 9'd0 : seq_idx + 9'd1;
            inj_cnt <= (inj_last || ERR_PERIOD == 0) ? '0 : inj_cnt + INJ_W'(1);
        end
    end

    // Strobe and start-of-frame are single-cycle; data and counters hold between symbols.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_prbs_ref <= 1'b0;
            o_tx_bit   <= 1'b0;
            cnt_bit    <= '0;
            cnt_inj    <= '0;
        end else begin
            o_valid <= symbol;
            o_sof   <= symbol && (seq_idx == 9'd0);
            if (symbol) begin
                o_prbs_ref <= lfsr_msb;
                o_tx_bit   <= lfsr_msb ^ inject;
                cnt_bit    <= sat_inc(cnt_bit);
                if (inject) begin
                    cnt_inj <= sat_inc(cnt_inj);
                end
            end
        end
    end

    assign o_counterBit = cnt_bit;
    assign o_counterInj = cnt_inj;

endmodule

// File: tb/tb_prbs9_tx_source.sv
// Directed self-checking bench for prbs9_tx_source (OS=4/ERR_PERIOD=10 and
// OS=1/ERR_PERIOD=1 instances sharing one clock and reset).
module tb_prbs9_tx_source;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        inj_en = 1'b0;
    logic        inj_en_b = 1'b1;
    logic        valid, prbs_ref, tx_bit, sof;
    logic [63:0] cnt_bit, cnt_inj;
    logic        valid_b, prbs_ref_b, tx_bit_b, sof_b;
    logic [63:0] cnt_bit_b, cnt_inj_b;

    int checks = 0;
    int passes = 0;

    localparam logic [8:0] SEED_BITS = 9'h1AA;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clock = ~clock;

    prbs9_tx_source #(.SEED(9'h1AA), .OS(4), .ERR_PERIOD(10)) dut (
        .clock        (clock),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_err_inj_en (inj_en),
        .o_valid      (valid),
        .o_prbs_ref   (prbs_ref),
        .o_tx_bit     (tx_bit),
        .o_sof        (sof),
        .o_counterBit (cnt_bit),
        .o_counterInj (cnt_inj)
    );

    prbs9_tx_source #(.SEED(9'h1AA), .OS(1), .ERR_PERIOD(1)) dut_b (
        .clock        (clock),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_err_inj_en (inj_en_b),
        .o_valid      (valid_b),
        .o_prbs_ref   (prbs_ref_b),
        .o_tx_bit     (tx_bit_b),
        .o_sof        (sof_b),
        .o_counterBit (cnt_bit_b),
        .o_counterInj (cnt_inj_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Advances until a strobe is seen; running out of budget is a failure.
    task automatic wait_symbol(output int edges);
        logic got;
        got = 1'b0;
        edges = 0;
        while (!got && edges < 16) begin
            step();
            edges++;
            got = valid;
        end
        if (!got) begin
            checks++;
            $display("[TB] FAIL wait_symbol: no o_valid within %0d edges", edges);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        inj_en = 1'b1;
        do_reset();
        checks++;
        if ({valid, prbs_ref, tx_bit, sof} !== 4'b0000 || cnt_bit !== 64'd0 || cnt_inj !== 64'd0)
            $display("[TB] FAIL reset_outputs: got v=%b r=%b t=%b s=%b cb=%0d ci=%0d, want all 0",
                     valid, prbs_ref, tx_bit, sof, cnt_bit, cnt_inj);
        else passes++;
        inj_en = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            checks++;
            if (valid !== ((e % 4) == 0))
                $display("[TB] FAIL strobe_edge%0d: got %b want %b", e, valid, ((e % 4) == 0));
            else passes++;
            if (e == 4) begin
                checks++;
                if (sof !== 1'b1 || prbs_ref !== 1'b1 || cnt_bit !== 64'd1)
                    $display("[TB] FAIL first_symbol: got sof=%b ref=%b cb=%0d want 1 1 1", sof, prbs_ref, cnt_bit);
                else passes++;
            end
            if (e == 8) begin
                checks++;
                if (sof !== 1'b0)
                    $display("[TB] FAIL sof_second: got %b want 0", sof);
                else passes++;
            end
        end
    endtask

    task automatic test_sequence();
        logic bits [0:1022];
        logic sofs [0:1022];
        int   edges, bad_period, bad_sof, bad_tx, bad_gap;
        logic [63:0] cnt_at_1022;
        bad_period = 0; bad_sof = 0; bad_tx = 0; bad_gap = 0;
        cnt_at_1022 = '0;
        inj_en = 1'b0;
        do_reset();
        for (int i = 0; i < 1023; i++) begin
            wait_symbol(edges);
            bits[i] = prbs_ref;
            sofs[i] = sof;
            if (edges != 4) bad_gap++;
            if (tx_bit !== prbs_ref) bad_tx++;
            if (i == 1021) cnt_at_1022 = cnt_bit;
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bits[i] !== SEED_BITS[8-i])
                $display("[TB] FAIL seed_bit%0d: got %b want %b", i, bits[i], SEED_BITS[8-i]);
            else passes++;
        end
        for (int i = 511; i < 1022; i++)
            if (bits[i] !== bits[i-511]) bad_period++;
        for (int i = 0; i < 1023; i++)
            if (sofs[i] !== (i == 0 || i == 511 || i == 1022)) bad_sof++;
        checks++;
        if (bad_period != 0) $display("[TB] FAIL period_511: got %0d differing bits want 0", bad_period);
        else passes++;
        checks++;
        if (bad_sof != 0) $display("[TB] FAIL sof_positions: got %0d wrong flags want 0", bad_sof);
        else passes++;
        checks++;
        if (bad_gap != 0) $display("[TB] FAIL strobe_spacing: got %0d irregular gaps want 0", bad_gap);
        else passes++;
        checks++;
        if (bad_tx != 0) $display("[TB] FAIL tx_clean: got %0d tx/ref differences want 0", bad_tx);
        else passes++;
        checks++;
        if (cnt_at_1022 !== 64'd1022) $display("[TB] FAIL counter_bit_1022: got %0d want 1022", cnt_at_1022);
        else passes++;
    endtask

    task automatic test_injection();
        int edges, bad_inj, bad_gate;
        bad_inj = 0; bad_gate = 0;
        inj_en = 1'b1;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            wait_symbol(edges);
            if ((tx_bit !== prbs_ref) != ((i % 10) == 9)) bad_inj++;
        end
        checks++;
        if (bad_inj != 0) $display("[TB] FAIL inject_pattern: got %0d wrong symbols want 0", bad_inj);
        else passes++;
        checks++;
        if (cnt_inj !== 64'd10 || cnt_bit !== 64'd100)
            $display("[TB] FAIL inject_counts: got inj=%0d bit=%0d want 10 100", cnt_inj, cnt_bit);
        else passes++;
        // Arm only between strobes; symbols 109 and 119 must stay clean.
        for (int i = 100; i < 120; i++) begin
            inj_en = 1'b1;
            step();
            step();
            inj_en = 1'b0;
            step();
            if (valid !== 1'b0) bad_gate++;
            step();
            if (valid !== 1'b1 || tx_bit !== prbs_ref) bad_gate++;
        end
        checks++;
        if (bad_gate != 0 || cnt_inj !== 64'd10)
            $display("[TB] FAIL inject_gating: got %0d bad symbols inj=%0d want 0 10", bad_gate, cnt_inj);
        else passes++;
    endtask

    task automatic test_enable_freeze();
        int edges, bad_hold;
        bad_hold = 0;
        inj_en = 1'b0;
        do_reset();
        wait_symbol(edges);
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (valid !== 1'b0 || prbs_ref !== 1'b1 || tx_bit !== 1'b1 || sof !== 1'b0 ||
                cnt_bit !== 64'd1 || cnt_inj !== 64'd0) bad_hold++;
        end
        checks++;
        if (bad_hold != 0) $display("[TB] FAIL freeze_hold: got %0d bad cycles want 0", bad_hold);
        else passes++;
        enable = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL resume_early: got valid=%b want 0", valid);
        else passes++;
        step();
        checks++;
        if (valid !== 1'b1 || prbs_ref !== 1'b1 || cnt_bit !== 64'd2)
            $display("[TB] FAIL resume_strobe: got v=%b r=%b cb=%0d want 1 1 2", valid, prbs_ref, cnt_bit);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int edges, bad_seq;
        bad_seq = 0;
        inj_en = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) wait_symbol(edges);
        step();
        step();
        do_reset();
        checks++;
        if ({valid, prbs_ref, tx_bit, sof} !== 4'b0000 || cnt_bit !== 64'd0 || cnt_inj !== 64'd0)
            $display("[TB] FAIL mid_reset: got v=%b r=%b t=%b s=%b cb=%0d ci=%0d want all 0",
                     valid, prbs_ref, tx_bit, sof, cnt_bit, cnt_inj);
        else passes++;
        for (int i = 0; i < 9; i++) begin
            wait_symbol(edges);
            if (edges != 4 || prbs_ref !== SEED_BITS[8-i] || tx_bit !== SEED_BITS[8-i]) bad_seq++;
        end
        checks++;
        if (bad_seq != 0 || cnt_bit !== 64'd9)
            $display("[TB] FAIL mid_reset_restart: got %0d bad symbols cb=%0d want 0 9", bad_seq, cnt_bit);
        else passes++;
        inj_en = 1'b0;
    endtask

    task automatic test_lockup();
        int edges, bad_seq, early;
        bad_seq = 0; early = 0;
        do_reset();
        wait_symbol(edges);
        step();
        step();
        step();
        force dut.u_lfsr.state = 9'h000;
        #1;
        release dut.u_lfsr.state;
        step();
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL lockup_no_strobe: got valid=%b want 0", valid);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (valid !== 1'b0) early++;
        end
        step();
        checks++;
        if (early != 0 || valid !== 1'b1)
            $display("[TB] FAIL lockup_phase: got early=%0d valid=%b want 0 1", early, valid);
        else passes++;
        if (prbs_ref !== SEED_BITS[8]) bad_seq++;
        for (int i = 1; i < 9; i++) begin
            wait_symbol(edges);
            if (prbs_ref !== SEED_BITS[8-i]) bad_seq++;
        end
        checks++;
        if (bad_seq != 0 || cnt_bit !== 64'd10)
            $display("[TB] FAIL lockup_reseed: got %0d bad bits cb=%0d want 0 10", bad_seq, cnt_bit);
        else passes++;
    endtask

    task automatic test_saturation();
        int edges;
        do_reset();
        wait_symbol(edges);
        force dut.cnt_bit = ALL_ONES;
        #1;
        release dut.cnt_bit;
        for (int i = 0; i < 2; i++) begin
            wait_symbol(edges);
            checks++;
            if (cnt_bit !== ALL_ONES) $display("[TB] FAIL counter_saturate%0d: got %h want %h", i, cnt_bit, ALL_ONES);
            else passes++;
        end
    endtask

    task automatic test_os1_inject_all();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            if (valid_b !== 1'b1 || prbs_ref_b !== SEED_BITS[8-i] || tx_bit_b !== ~SEED_BITS[8-i] ||
                sof_b !== (i == 0) || cnt_inj_b !== 64'(i + 1)) bad++;
        end
        checks++;
        if (bad != 0 || cnt_bit_b !== 64'd9)
            $display("[TB] FAIL os1_inject_all: got %0d bad edges cb=%0d want 0 9", bad, cnt_bit_b);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_injection();
        test_enable_freeze();
        test_reset_mid();
        test_lockup();
        test_saturation();
        test_os1_inject_all();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
